seq_divider_16bit: RTL and testbench

- Iterative unsigned restoring divider, the inverse counterpart of the multiplier datapath.
- Produces one quotient bit per clock from a WIDTH-bit trial subtractor.
  - The subtractor computes remainder + ~divisor with carry-in 1; carry-out 1 means no borrow.
- Valid/ready handshakes on both sides, so it drops into the same streaming datapath as the multiplier.

---
 rtl/seq_divider_16bit.sv | 116 +++++++++++
 tb/tb_seq_divider_16bit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - iterative unsigned restoring divider with valid/ready handshakes
module seq_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;
    logic             diff_msb_unused;

    // Trial subtraction: shifted remainder plus inverted divisor with carry-in; carry-out means no borrow
    always_comb begin
        trial           = {rem_q, quo_q[WIDTH-1]};
        diff            = {1'b0, trial} + {1'b0, ~{1'b0, dvs_q}} + {{(WIDTH + 1){1'b0}}, 1'b1};
        no_borrow       = diff[WIDTH+1];
        diff_msb_unused = diff[WIDTH];
    end

    // Next-state, datapath and handshake logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quo_d = {quo_q[WIDTH-2:0], no_borrow};
                rem_d = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q - {{(CNT_W - 1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb/tb_seq_divider_16bit.sv - self-checking bench for seq_divider_16bit
module tb_seq_divider_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          stall;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    seq_divider_16bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // in_ready and out_valid are mutually exclusive whenever out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (in_ready && out_valid) begin
                bad++;
                $display("FAIL handshake_overlap: in_ready=%0b out_valid=%0b at %0t", in_ready, out_valid, $time);
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                         input logic [15:0] er, input logic ez, input int stall, input logic noisy);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        e.q   = eq;
        e.r   = er;
        e.z   = ez;
        e.lat = (b == 16'd0) ? 0 : 16;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        sb.push_back(e);
        in_valid = noisy ? 1'($urandom) : 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (noisy) begin
                in_valid = 1'($urandom);
                dividend = 16'($urandom);
                divisor  = 16'($urandom);
            end
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", n, e.lat);
        for (int i = 0; i < stall; i++) begin
            check("stall_quotient", {16'd0, quotient}, {16'd0, e.q});
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            if (noisy) in_valid = 1'($urandom);
        end
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("quotient", {16'd0, quotient}, {16'd0, e.q});
        check("remainder", {16'd0, remainder}, {16'd0, e.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("taken_out_valid", {31'd0, out_valid}, 32'd0);
        check("taken_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb, rq, rr;
        logic        rz;

        vecs[0] = '{a: 16'd100,   b: 16'd7,    q: 16'd14,   r: 16'd2,   z: 1'b0, stall: 0};
        vecs[1] = '{a: 16'hFFFF,  b: 16'd1,    q: 16'hFFFF, r: 16'd0,   z: 1'b0, stall: 1};
        vecs[2] = '{a: 16'd3,     b: 16'd10,   q: 16'd0,    r: 16'd3,   z: 1'b0, stall: 0};
        vecs[3] = '{a: 16'd5,     b: 16'd0,    q: 16'hFFFF, r: 16'd5,   z: 1'b1, stall: 0};
        vecs[4] = '{a: 16'd0,     b: 16'd0,    q: 16'hFFFF, r: 16'd0,   z: 1'b1, stall: 2};
        vecs[5] = '{a: 16'd1000,  b: 16'd33,   q: 16'd30,   r: 16'd10,  z: 1'b0, stall: 10};
        vecs[6] = '{a: 16'hFFFF,  b: 16'hFFFF, q: 16'd1,    r: 16'd0,   z: 1'b0, stall: 0};
        vecs[7] = '{a: 16'h8000,  b: 16'd3,    q: 16'd10922, r: 16'd2,  z: 1'b0, stall: 0};
        vecs[8] = '{a: 16'hFFFE,  b: 16'hFFFF, q: 16'd0,    r: 16'hFFFE, z: 1'b0, stall: 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].stall, 1'b1);
        end

        // reset in the middle of a calculation discards the operation
        in_valid = 1'b1;
        dividend = 16'hABCD;
        divisor  = 16'h0012;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", {16'd0, quotient}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'hABCD, 16'h0012, 16'h098B, 16'h0007, 1'b0, 0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 16'hFFFF;
                1: ra = 16'h0000;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: rb = 16'h0001;
                3: rb = 16'($urandom_range(1, 255));
                default: rb = 16'($urandom);
            endcase
            if (rb == 16'd0) begin
                rq = 16'hFFFF;
                rr = ra;
                rz = 1'b1;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
                rz = 1'b0;
            end
            do_op(ra, rb, rq, rr, rz, $urandom_range(0, 3), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
